// File: rtl/sync_frame_tx.sv
// Serial framing transmitter: sends SYNC (MSB first), then the payload (MSB first),
// then IDLE_GAP forced idle cycles. The line rests at 0 outside frames.
module sync_frame_tx #(
   parameter int                DATA_W   = 8,
   parameter int                SYNC_W   = 4,
   parameter logic [SYNC_W-1:0] SYNC     = 4'b1101,
   parameter int                IDLE_GAP = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              dout,
   output logic              dout_valid,
   output logic              sync_phase,
   output logic              done
);

   localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int MAX_LEN = (MAX_SD > IDLE_GAP) ? MAX_SD : IDLE_GAP;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
   logic [SYNC_W-1:0]  sync_sh, sync_sh_nxt;
   logic [DATA_W-1:0]  data_sh, data_sh_nxt;
   logic               dout_nxt, dout_valid_nxt, sync_phase_nxt, done_nxt;

   assign cnt_inc  = cnt + 1'b1;
   assign tx_ready = (state == S_IDLE) && !rst;

   // The outputs are registered, so each branch computes the bit for the next cycle;
   // cnt is the index of the bit currently on the line within its phase.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      sync_sh_nxt    = sync_sh;
      data_sh_nxt    = data_sh;
      dout_nxt       = 1'b0;
      dout_valid_nxt = 1'b0;
      sync_phase_nxt = 1'b0;
      done_nxt       = 1'b0;
      case (state)
         S_IDLE: begin
            if (tx_valid) begin
               state_nxt      = S_SYNC;
               cnt_nxt        = '0;
               dout_nxt       = SYNC[SYNC_W-1];
               sync_sh_nxt    = SYNC << 1;
               data_sh_nxt    = tx_data;
               dout_valid_nxt = 1'b1;
               sync_phase_nxt = 1'b1;
            end
         end
         S_SYNC: begin
            dout_valid_nxt = 1'b1;
            if (cnt == SYNC_LAST) begin
               state_nxt   = S_DATA;
               cnt_nxt     = '0;
               dout_nxt    = data_sh[DATA_W-1];
               data_sh_nxt = data_sh << 1;
               done_nxt    = (DATA_W == 1);
            end else begin
               cnt_nxt        = cnt_inc;
               dout_nxt       = sync_sh[SYNC_W-1];
               sync_sh_nxt    = sync_sh << 1;
               sync_phase_nxt = 1'b1;
            end
         end
         S_DATA: begin
            if (cnt == DATA_LAST) begin
               cnt_nxt   = '0;
               state_nxt = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
            end else begin
               cnt_nxt        = cnt_inc;
               dout_valid_nxt = 1'b1;
               dout_nxt       = data_sh[DATA_W-1];
               data_sh_nxt    = data_sh << 1;
               done_nxt       = (cnt_inc == DATA_LAST);
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         sync_phase <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         dout       <= dout_nxt;
         dout_valid <= dout_valid_nxt;
         sync_phase <= sync_phase_nxt;
         done       <= done_nxt;
      end
   end

   // Shift registers carry data only; they are always reloaded before use.
   always_ff @(posedge clk) begin
      sync_sh <= sync_sh_nxt;
      data_sh <= data_sh_nxt;
   end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: queue-based frame model checked every cycle, plus
// directed literal frames and a DATA_W=1 / IDLE_GAP=0 corner instance.
module tb_sync_frame_tx;

   localparam int SW  = 4;
   localparam int DW  = 8;
   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, dout, dout_valid, sync_phase, done;
   logic [0:0] c_data;
   logic       c_valid;
   logic       c_ready, c_dout, c_dout_valid, c_sync_phase, c_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   sync_frame_tx dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .dout(dout), .dout_valid(dout_valid), .sync_phase(sync_phase), .done(done)
   );

   sync_frame_tx #(.DATA_W(1), .SYNC_W(4), .SYNC(4'b1101), .IDLE_GAP(0)) dut_c (
      .clk(clk), .rst(rst), .tx_data(c_data), .tx_valid(c_valid), .tx_ready(c_ready),
      .dout(c_dout), .dout_valid(c_dout_valid), .sync_phase(c_sync_phase), .done(c_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Trace of every cycle, sampled mid-cycle, indexed by cycle number.
   logic tr_dout [4096];
   logic tr_vld  [4096];
   logic tr_sync [4096];
   logic tr_done [4096];
   logic tr_rdy  [4096];
   logic tr_cdout[4096];
   logic tr_cdone[4096];
   logic tr_csync[4096];
   logic tr_crdy [4096];

   always @(negedge clk) begin
      tr_dout[cyc & 4095]  <= dout;
      tr_vld[cyc & 4095]   <= dout_valid;
      tr_sync[cyc & 4095]  <= sync_phase;
      tr_done[cyc & 4095]  <= done;
      tr_rdy[cyc & 4095]   <= tx_ready;
      tr_cdout[cyc & 4095] <= c_dout;
      tr_cdone[cyc & 4095] <= c_done;
      tr_csync[cyc & 4095] <= c_sync_phase;
      tr_crdy[cyc & 4095]  <= c_ready;
   end

   // Model: a handshake in an idle cycle schedules the whole frame plus gap as a
   // list of per-cycle {dout, dout_valid, sync_phase, done}; a cycle is busy while
   // an entry is being played out.
   logic [3:0] mq[$];
   logic [3:0] m_cur = 4'b0;
   bit         m_busy = 1'b0;
   bit         m_seen = 1'b0;
   logic [3:0] sync_word = 4'b1101;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_busy = 1'b0;
         m_cur  = 4'b0;
         m_seen = 1'b1;
      end else begin
         if (!m_busy && tx_valid && m_seen) begin
            for (int i = 0; i < SW; i++) mq.push_back({sync_word[SW-1-i], 1'b1, 1'b1, 1'b0});
            for (int j = 0; j < DW; j++) mq.push_back({tx_data[DW-1-j], 1'b1, 1'b0, (j == DW-1)});
            for (int g = 0; g < GAP; g++) mq.push_back(4'b0000);
         end
         if (mq.size() > 0) begin
            m_cur  = mq.pop_front();
            m_busy = 1'b1;
         end else begin
            m_cur  = 4'b0;
            m_busy = 1'b0;
         end
      end
   end

   task automatic compare_loop();
      logic [4:0] exp_v, act_v;
      forever begin
         @(negedge clk);
         if (m_seen) begin
            exp_v = {m_cur, (!m_busy && !rst)};
            act_v = {dout, dout_valid, sync_phase, done, tx_ready};
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL model_cycle %0d: dout/vld/sync/done/rdy got %b expected %b", cyc, act_v, exp_v);
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] grab(input int sel, input int hs, input int n);
      logic [31:0] v;
      logic        b;
      v = '0;
      if (hs < 0) return 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         case (sel)
            0:       b = tr_dout[(hs+i) & 4095];
            1:       b = tr_vld[(hs+i) & 4095];
            2:       b = tr_sync[(hs+i) & 4095];
            3:       b = tr_done[(hs+i) & 4095];
            4:       b = tr_rdy[(hs+i) & 4095];
            5:       b = tr_cdout[(hs+i) & 4095];
            6:       b = tr_cdone[(hs+i) & 4095];
            7:       b = tr_csync[(hs+i) & 4095];
            default: b = tr_crdy[(hs+i) & 4095];
         endcase
         v = {v[30:0], b};
      end
      return v;
   endfunction

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input bit keep, output int hs);
      int n;
      n  = 0;
      hs = -1;
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      while (!tx_ready && n < 100) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         n++;
      end
      if (!tx_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: tx_ready got 0 for 100 cycles expected 1");
         tx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         if (!keep) tx_valid = 1'b0;
         hs = cyc;
      end
   endtask

   task automatic c_send(input logic d, output int hs);
      int n;
      n  = 0;
      hs = -1;
      @(posedge clk);
      #1;
      c_valid = 1'b1;
      c_data  = d;
      @(negedge clk);
      while (!c_ready && n < 100) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         n++;
      end
      if (!c_ready) begin
         checks++;
         errors++;
         $display("FAIL c_send_timeout: c_ready got 0 for 100 cycles expected 1");
      end else begin
         @(posedge clk);
         #1;
         hs = cyc;
      end
      c_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hs, hs1, hs2, gap_len;
      logic [11:0] fr;
      logic [3:0]  win;
      logic [11:0] hits;

      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      c_valid  = 1'b0;
      c_data   = '0;

      fork
         compare_loop();
      join_none

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_outputs", {dout, dout_valid, sync_phase, done, tx_ready}, 5'b0);
      chk("rst_c_outputs", {c_dout, c_dout_valid, c_sync_phase, c_done, c_ready}, 5'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", tx_ready, 1'b1);
      chk("c_ready_after_rst", c_ready, 1'b1);

      // Basic frame
      send(8'hA5, 1'b0, hs);
      wait_cyc(hs + 17);
      chk("a5_dout", grab(0, hs, 12), 32'hDA5);
      chk("a5_sync", grab(2, hs, 12), 32'hF00);
      chk("a5_done", grab(3, hs, 12), 32'h001);
      chk("a5_valid", grab(1, hs, 12), 32'hFFF);
      chk("a5_after_valid", grab(1, hs + 12, 4), 32'h0);

      // Back-to-back frames with tx_valid held
      send(8'hFF, 1'b1, hs1);
      send(8'h00, 1'b0, hs2);
      wait_cyc(hs2 + 14);
      gap_len = hs2 - hs1 - 12;
      chk("b2b_gap_len", gap_len, 2);
      chk("b2b_gap_line", grab(0, hs1 + 12, 2) | grab(1, hs1 + 12, 2), 32'h0);
      chk("b2b_frame1", grab(0, hs1, 12), 32'hDFF);
      chk("b2b_frame2", grab(0, hs2, 12), 32'hD00);
      chk("b2b_ready_pulses", $countones(grab(4, hs1, 26)), 1);

      // Busy ignore
      send(8'hA5, 1'b0, hs);
      wait_cyc(hs + 6);
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      wait_cyc(hs + 31);
      chk("busy_frame", grab(0, hs, 12), 32'hDA5);
      chk("busy_no_second", grab(1, hs + 12, 18), 32'h0);

      // Reset on the 3rd payload bit
      send(8'hA5, 1'b0, hs);
      wait_cyc(hs + 6);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wait_cyc(hs + 8);
      chk("midrst_line", {grab(0, hs + 7, 1), grab(1, hs + 7, 1), grab(3, hs + 7, 1)}, 96'h0);
      chk("midrst_ready", grab(4, hs + 7, 1), 32'h1);
      send(8'h96, 1'b0, hs);
      wait_cyc(hs + 13);
      chk("midrst_new_frame", grab(0, hs, 12), 32'hD96);
      chk("midrst_new_sync", grab(2, hs, 12), 32'hF00);

      // Sync pattern inside the payload
      send(8'h0D, 1'b0, hs);
      wait_cyc(hs + 13);
      fr = grab(0, hs, 12);
      chk("pat_frame", fr, 32'hD0D);
      win  = '0;
      hits = '0;
      for (int i = 0; i < 12; i++) begin
         win = {win[2:0], fr[11-i]};
         if (i >= 3 && win == 4'b1101) hits[i] = 1'b1;
      end
      chk("pat_hit_positions", hits, 32'h808);
      chk("pat_hit_count", $countones(hits), 2);

      // DATA_W = 1, IDLE_GAP = 0 corner
      c_send(1'b1, hs);
      wait_cyc(hs + 7);
      chk("corner_dout", grab(5, hs, 5), 32'h1B);
      chk("corner_done", grab(6, hs, 5), 32'h01);
      chk("corner_sync", grab(7, hs, 5), 32'h1E);
      chk("corner_ready", grab(8, hs + 4, 2), 32'h1);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         rst      = ($urandom_range(0, 149) == 0);
         tx_valid = ($urandom_range(0, 3) != 0);
         tx_data  = 8'($urandom);
      end
      rst      = 1'b0;
      tx_valid = 1'b0;
      wait_cyc(cyc + 25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
